// File: rtl/parking_gate_ctrl.sv
// Parking-lot gate controller: edge-detects the entry and exit sensors, queues one request per source,
// and serves requests one at a time through a timed barrier FSM that owns the occupancy count.
module parking_gate_ctrl #(
  parameter int CAPACITY   = 20,
  parameter int CNT_W      = 5,
  parameter int GATE_TICKS = 2000,
  parameter int TICK_W     = 11
) (
  input  logic             clk_slow,
  input  logic             rst_n,
  input  logic             ent_in,
  input  logic             ext_in,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             gate_in,
  output logic             gate_out,
  output logic             reject,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT} state_t;

  localparam logic [CNT_W-1:0]  CAP       = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(GATE_TICKS - 1);

  state_t            state_reg;
  logic [TICK_W-1:0] timer_reg;
  logic              ent_prev_reg;
  logic              ext_prev_reg;
  logic              pend_in_reg;
  logic              pend_out_reg;
  logic              rise_in;
  logic              rise_out;

  assign rise_in  = ent_in & ~ent_prev_reg;
  assign rise_out = ext_in & ~ext_prev_reg;

  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      // History resets high so a sensor held active across reset release is not a new arrival.
      ent_prev_reg <= 1'b1;
      ext_prev_reg <= 1'b1;
      pend_in_reg  <= 1'b0;
      pend_out_reg <= 1'b0;
      state_reg    <= IDLE;
      timer_reg    <= '0;
      occupancy    <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      gate_in      <= 1'b0;
      gate_out     <= 1'b0;
      reject       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      ent_prev_reg <= ent_in;
      ext_prev_reg <= ext_in;
      reject       <= 1'b0;

      case (state_reg)
        IDLE: begin
          // Exit first: it frees a space the waiting entry may need.
          if (pend_out_reg && !empty) begin
            state_reg    <= OPEN_OUT;
            timer_reg    <= '0;
            occupancy    <= occupancy - ONE;
            full         <= 1'b0;
            empty        <= (occupancy == ONE);
            pend_out_reg <= 1'b0;
            gate_out     <= 1'b1;
            busy         <= 1'b1;
          end else if (pend_out_reg) begin
            pend_out_reg <= 1'b0;
          end else if (pend_in_reg && !full) begin
            state_reg    <= OPEN_IN;
            timer_reg    <= '0;
            occupancy    <= occupancy + ONE;
            full         <= (occupancy == CAP - ONE);
            empty        <= 1'b0;
            pend_in_reg  <= 1'b0;
            gate_in      <= 1'b1;
            busy         <= 1'b1;
          end else if (pend_in_reg) begin
            reject       <= 1'b1;
            pend_in_reg  <= 1'b0;
          end
        end
        OPEN_IN, OPEN_OUT: begin
          if (timer_reg == LAST_TICK) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            gate_in   <= 1'b0;
            gate_out  <= 1'b0;
            busy      <= 1'b0;
          end else begin
            timer_reg <= timer_reg + TICK_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Placed after the FSM so a same-cycle rise overrides a grant/reject clear.
      if (rise_in)  pend_in_reg  <= 1'b1;
      if (rise_out) pend_out_reg <= 1'b1;
    end
  end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
Central controller of the parking-lot counter. It takes the debounced entry and exit sensor levels, detects their rising edges, and latches each one as a pending request. It then arbitrates the two request sources onto a single gate-service state machine. The block owns the occupancy count, the full/empty flags, and the barrier-open outputs. It sits between the per-button debouncers and the display/driver logic.

Parameters:
CAPACITY, 20, maximum occupancy (1..2^CNT_W-1)
CNT_W, 5, width of occupancy count
GATE_TICKS, 2000, clock cycles a barrier stays open (2 s at 1 kHz)
TICK_W, 11, width of gate timer (2^TICK_W > GATE_TICKS)

Ports:
clk_slow  in  1  system clock (1 kHz tick domain, same as debouncers)
rst_n  in  1  asynchronous active-low reset
ent_in  in  1  debounced entry sensor, 1 = car present
ext_in  in  1  debounced exit sensor, 1 = car present
occupancy  out  CNT_W  current car count, 0..CAPACITY
full  out  1  occupancy == CAPACITY
empty  out  1  occupancy == 0
gate_in  out  1  entry barrier open
gate_out  out  1  exit barrier open
reject  out  1  one-cycle pulse: entry refused because lot is full
busy  out  1  FSM not in IDLE

Behaviour:
- Clocking and reset: single clock, clk_slow. Reset is asynchronous and active-low on rst_n; all state resets, nothing is gated.
- Reset values:
  - occupancy=0, empty=1, full=0, gate_in=0, gate_out=0, reject=0, busy=0.
  - FSM=IDLE, timer=0, pend_in=0, pend_out=0.
  - Edge-detect history registers reset to 1, so a sensor held active through reset release produces no request.
- Edge detection: rise_x = x_in & ~x_prev. x_prev is updated every cycle.
- Pending flags:
  - Set on rise_x; cleared when the request is granted or rejected.
  - A rise on a flag that is already pending is dropped (queue depth is 1 per source).
  - If a rise and a clear of the same flag happen in the same cycle, set wins.
- FSM states: IDLE, OPEN_IN, OPEN_OUT.
- IDLE, evaluated every cycle, first match wins:
  1. pend_out & ~empty -> OPEN_OUT. occupancy -= 1 and timer loads 0 on the transition edge; clear pend_out.
  2. pend_out & empty -> clear pend_out, stay IDLE, no pulse (phantom exit is ignored).
  3. pend_in & ~full -> OPEN_IN. occupancy += 1 and timer loads 0; clear pend_in.
  4. pend_in & full -> reject=1 for exactly one cycle; clear pend_in; stay IDLE.
- Arbitration when both flags are pending: exit has fixed priority, because it frees space. The entry stays pending and is served after the exit cycle completes. Rule 2 (phantom exit) consumes the IDLE cycle, so a simultaneous entry is evaluated in the next cycle.
- OPEN_IN / OPEN_OUT:
  - gate_in (resp. gate_out) =1 for the whole state; busy=1.
  - The timer increments each cycle. When timer == GATE_TICKS-1 the FSM returns to IDLE, so the barrier is high for exactly GATE_TICKS cycles.
  - New edges arriving during OPEN are latched as pending, not lost.
- Latency: rise sampled at edge N -> pending visible at N+1 -> state, gate, and occupancy updated at N+2.
- Flags: full and empty are registered, consistent with occupancy in the same cycle (derived from the next-state count).
- Count arithmetic:
  - Occupancy never wraps: it never exceeds CAPACITY and never goes below 0, guaranteed by the full/empty checks above.
  - Only one count change per service cycle.
- Reset mid-OPEN: barrier drops immediately, count returns to 0, pending requests are discarded.

Test Plan:
- Reset release with ent_in held 1 -> no request; occupancy=0, gate_in=0, empty=1 after 10 cycles. Drop then raise ent_in -> gate_in high 2 cycles after the rise, for exactly 2000 cycles; occupancy=1.
- 20 entries from empty (GATE_TICKS=4 for speed) -> occupancy=20, full=1. 21st entry -> reject pulse of 1 cycle, gate_in stays 0, occupancy stays 20.
- Exit rise with occupancy=0 -> gate_out never asserts, occupancy=0, no reject.
- With occupancy=5, ent_in and ext_in rise in the same cycle -> OPEN_OUT first (occupancy=4), then OPEN_IN immediately after (occupancy=5). Total busy = 2*GATE_TICKS cycles.
- Two entry rises during one OPEN_IN window -> only one extra service (depth-1 pending); final occupancy = start+2.
- rst_n pulsed low mid-OPEN_OUT with occupancy=7 -> gate_out=0 and occupancy=0 asynchronously, with no clock edge required.
